rtc_timer_sched: RTL and testbench
==================================

RTC_TIMER_SCHED -- requirements
Module: rtc_timer_sched

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning the number of software timer slots (range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock, rising-edge.
REQ-003 SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port arm_i, input, 1 bit, a one-cycle strobe that arms slot slot_i with deadline_i.
REQ-005 SHALL have port cancel_i, input, 1 bit, a one-cycle strobe that disarms slot slot_i.
REQ-006 SHALL have port slot_i, input, $clog2(NUM_SLOTS) bits, the slot index for arm/cancel/ack.
REQ-007 SHALL have port deadline_i, input, 64 bits, the absolute mtime deadline.
REQ-008 SHALL have port ack_i, input, 1 bit, a one-cycle strobe that clears expired_o[slot_i].
REQ-009 SHALL have port mti_i, input, 1 bit, the registered timer interrupt from the RTC.
REQ-010 SHALL have port rtc_en_o, input-side RTC port, output, 1 bit, the RTC access enable.
REQ-011 SHALL have port rtc_we_o, output, 8 bits, the RTC byte write enables.
REQ-012 SHALL have port rtc_addr_o, output, 4 bits, the RTC register address.
REQ-013 SHALL have port rtc_data_o, output, 64 bits, the RTC write data.
REQ-014 SHALL have port expired_o, output, NUM_SLOTS bits, the sticky per-slot expiry flags.
REQ-015 SHALL have port irq_o, output, 1 bit, equal to OR of expired_o.
REQ-016 SHALL have port busy_o, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-017 SHALL hold per slot an armed bit and a 64-bit deadline register; arm/cancel/ack SHALL be accepted in every state, with no backpressure.
REQ-018 SHALL run the FSM IDLE -> SCAN -> PROGRAM -> WAIT -> IDLE.
- IDLE->SCAN: on a pending rescan request.
- SCAN: one slot per cycle, NUM_SLOTS cycles; tracks the minimum armed deadline; ties go to the lowest index.
- PROGRAM: exactly one cycle, then WAIT.
- WAIT: exactly 2 cycles, then IDLE.
REQ-019 SHALL set the rescan request on any arm or cancel, and on any expiry; a request raised during SCAN/PROGRAM/WAIT SHALL cause a new SCAN immediately after WAIT.
REQ-020 In PROGRAM, SHALL drive rtc_en_o=1, rtc_we_o=8'hFF, rtc_addr_o=4'h8, rtc_data_o=min deadline (or 64'hFFFF_FFFF_FFFF_FFFF if no slot is armed), and SHALL latch cur_slot/cur_valid.
REQ-021 Outside PROGRAM, SHALL drive rtc_en_o=0, rtc_we_o=0, rtc_addr_o=0, rtc_data_o=0.
REQ-022 SHALL ignore mti_i except in IDLE, so that a stale interrupt from the previous mtimecmp is masked during WAIT.
REQ-023 In IDLE with mti_i=1 and cur_valid=1, SHALL set expired_o[cur_slot], clear its armed bit, clear cur_valid and raise a rescan request, all in the same edge.
REQ-024 Slots armed with an equal or already-past deadline SHALL expire one at a time, each through a full rescan.
REQ-025 If arm and expiry hit the same slot in the same cycle, the arm SHALL win: the new deadline is armed and the slot is not disarmed, while expired_o is still set.
REQ-026 If cancel and arm target the same slot in the same cycle, the arm SHALL win.
REQ-027 Cancelling cur_slot SHALL clear cur_valid.
REQ-028 If ack and a set of the same bit occur in the same cycle, the set SHALL win.
REQ-029 Worst-case reprogram latency from a request SHALL be NUM_SLOTS+3 cycles, plus up to NUM_SLOTS+3 more if the request arrives mid-sequence.

Reset
REQ-030 On reset_n=0, SHALL asynchronously clear to 0 all of: armed bits, deadlines, expired_o, irq_o, busy_o, cur_valid, and all rtc_* outputs; state SHALL be IDLE.
REQ-031 SHALL set the rescan request to 1 on reset, so that the first sequence programs mtimecmp to all-ones.
REQ-032 Reset asserted mid-SCAN/PROGRAM SHALL abort the sequence with no partial RTC write.

Configuration
REQ-033 With RTC_SCHED_OVERRUN_EN defined, SHALL add output overrun_o (NUM_SLOTS bits, reset 0), set when a slot expires while its expired_o bit is already 1, and cleared by ack_i for that slot.
REQ-034 Without RTC_SCHED_OVERRUN_EN, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-035 Reset release -> busy_o for 7 cycles (NUM_SLOTS=4), one PROGRAM write with rtc_data_o=64'hFFFF_FFFF_FFFF_FFFF and addr 4'h8.
REQ-036 Arm slot2=100, slot0=50 in consecutive cycles -> final PROGRAM writes 50; on mti_i, expired_o=4'b0001, then a write of 100.
REQ-037 Arm slot1=slot3=200 -> write 200 with cur_slot=1; mti -> expired 0010; next write 200; mti -> expired 1010; irq_o=1 until both are acked.
REQ-038 mti_i held high through WAIT after a write -> no expiry is recorded until IDLE.
REQ-039 Cancel the sole armed slot -> write all-ones, expired_o unchanged, irq_o=0.
REQ-040 With RTC_SCHED_OVERRUN_EN, expire slot0 twice without ack -> overrun_o[0]=1; ack -> expired_o[0]=0 and overrun_o[0]=0.

Source files
------------

// File: rtl/rtc_timer_sched.sv
// ============================================================================
// rtc_timer_sched : multiplexes NUM_SLOTS software timers onto one RTC mtimecmp
// Optional: RTC_SCHED_OVERRUN_EN adds overrun_o.      Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_timer_sched #(
   parameter int NUM_SLOTS = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         arm_i,
   input  logic                         cancel_i,
   input  logic [$clog2(NUM_SLOTS)-1:0] slot_i,
   input  logic [63:0]                  deadline_i,
   input  logic                         ack_i,
   input  logic                         mti_i,
   output logic                         rtc_en_o,
   output logic [7:0]                   rtc_we_o,
   output logic [3:0]                   rtc_addr_o,
   output logic [63:0]                  rtc_data_o,
   output logic [NUM_SLOTS-1:0]         expired_o,
   output logic                         irq_o,
   output logic                         busy_o
`ifdef RTC_SCHED_OVERRUN_EN
   ,
   output logic [NUM_SLOTS-1:0]         overrun_o
`endif
);

   localparam int              SW       = $clog2(NUM_SLOTS);
   localparam logic [SW-1:0]   LAST     = SW'(NUM_SLOTS - 1);
   localparam logic [63:0]     ALL_ONES = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PROGRAM = 2'd2,
      WAIT    = 2'd3
   } state_t;

   state_t                state_q;
   logic                  rescan_q;
   logic [SW-1:0]         scan_idx_q;
   logic [63:0]           min_q;
   logic [SW-1:0]         min_slot_q;
   logic                  min_valid_q;
   logic                  wait_cnt_q;
   logic [SW-1:0]         cur_slot_q;
   logic                  cur_valid_q;
   logic                  rtc_en_q;
   logic [7:0]            rtc_we_q;
   logic [3:0]            rtc_addr_q;
   logic [63:0]           rtc_data_q;
   logic                  busy_q;
   logic                  irq_q;
   logic [NUM_SLOTS-1:0]  armed_q, armed_d;
   logic [NUM_SLOTS-1:0]  expired_q, expired_d;
   logic [63:0]           deadline_q [NUM_SLOTS];
`ifdef RTC_SCHED_OVERRUN_EN
   logic [NUM_SLOTS-1:0]  overrun_q, overrun_d;
`endif

   logic                  w_slot_ok;
   logic                  w_arm;
   logic                  w_cancel;
   logic                  w_ack;
   logic                  w_expire;
   logic                  w_req;
   logic                  w_take;
   logic [63:0]           w_min_nxt;
   logic [SW-1:0]         w_slot_nxt;
   logic                  w_valid_nxt;

   // Arm beats cancel on the shared slot index; out-of-range indices are dropped.
   assign w_slot_ok = (32'(slot_i) < NUM_SLOTS);
   assign w_arm     = arm_i && w_slot_ok;
   assign w_cancel  = cancel_i && !arm_i && w_slot_ok;
   assign w_ack     = ack_i && w_slot_ok;
   assign w_expire  = (state_q == IDLE) && mti_i && cur_valid_q;
   assign w_req     = w_arm || w_cancel || w_expire;

   always_comb begin
      w_take      = armed_q[scan_idx_q] &&
                    (!min_valid_q || (deadline_q[scan_idx_q] < min_q));
      w_min_nxt   = w_take ? deadline_q[scan_idx_q] : min_q;
      w_slot_nxt  = w_take ? scan_idx_q : min_slot_q;
      w_valid_nxt = min_valid_q || w_take;
   end

   // Later assignments take priority: arm over expiry/cancel, set over ack.
   always_comb begin
      armed_d   = armed_q;
      expired_d = expired_q;
`ifdef RTC_SCHED_OVERRUN_EN
      overrun_d = overrun_q;
`endif
      if (w_expire) armed_d[cur_slot_q] = 1'b0;
      if (w_cancel) armed_d[slot_i] = 1'b0;
      if (w_arm)    armed_d[slot_i] = 1'b1;
      if (w_ack) begin
         expired_d[slot_i] = 1'b0;
`ifdef RTC_SCHED_OVERRUN_EN
         overrun_d[slot_i] = 1'b0;
`endif
      end
      if (w_expire) begin
`ifdef RTC_SCHED_OVERRUN_EN
         if (expired_q[cur_slot_q]) overrun_d[cur_slot_q] = 1'b1;
`endif
         expired_d[cur_slot_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q   <= '0;
         expired_q <= '0;
         irq_q     <= 1'b0;
`ifdef RTC_SCHED_OVERRUN_EN
         overrun_q <= '0;
`endif
         for (int i = 0; i < NUM_SLOTS; i++) deadline_q[i] <= '0;
      end else begin
         armed_q   <= armed_d;
         expired_q <= expired_d;
         irq_q     <= |expired_d;
`ifdef RTC_SCHED_OVERRUN_EN
         overrun_q <= overrun_d;
`endif
         if (w_arm) deadline_q[slot_i] <= deadline_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rescan_q    <= 1'b1;
         scan_idx_q  <= '0;
         min_q       <= '0;
         min_slot_q  <= '0;
         min_valid_q <= 1'b0;
         wait_cnt_q  <= 1'b0;
         cur_slot_q  <= '0;
         cur_valid_q <= 1'b0;
         rtc_en_q    <= 1'b0;
         rtc_we_q    <= '0;
         rtc_addr_q  <= '0;
         rtc_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         rtc_en_q   <= 1'b0;
         rtc_we_q   <= '0;
         rtc_addr_q <= '0;
         rtc_data_q <= '0;
         rescan_q   <= rescan_q || w_req;
         if (w_expire || (w_cancel && (slot_i == cur_slot_q))) cur_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (rescan_q) begin
                  state_q     <= SCAN;
                  busy_q      <= 1'b1;
                  rescan_q    <= w_req;
                  scan_idx_q  <= '0;
                  min_q       <= ALL_ONES;
                  min_slot_q  <= '0;
                  min_valid_q <= 1'b0;
               end
            end
            SCAN: begin
               min_q       <= w_min_nxt;
               min_slot_q  <= w_slot_nxt;
               min_valid_q <= w_valid_nxt;
               if (scan_idx_q == LAST) begin
                  state_q    <= PROGRAM;
                  rtc_en_q   <= 1'b1;
                  rtc_we_q   <= 8'hFF;
                  rtc_addr_q <= 4'h8;
                  rtc_data_q <= w_valid_nxt ? w_min_nxt : ALL_ONES;
               end else begin
                  scan_idx_q <= scan_idx_q + SW'(1);
               end
            end
            PROGRAM: begin
               state_q     <= WAIT;
               wait_cnt_q  <= 1'b0;
               cur_slot_q  <= min_slot_q;
               // A cancel landing in this very cycle must not be latched as live.
               cur_valid_q <= min_valid_q && !(w_cancel && (slot_i == min_slot_q));
            end
            WAIT: begin
               if (wait_cnt_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  wait_cnt_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rtc_en_o   = rtc_en_q;
   assign rtc_we_o   = rtc_we_q;
   assign rtc_addr_o = rtc_addr_q;
   assign rtc_data_o = rtc_data_q;
   assign expired_o  = expired_q;
   assign irq_o      = irq_q;
   assign busy_o     = busy_q;
`ifdef RTC_SCHED_OVERRUN_EN
   assign overrun_o  = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rtc_timer_sched.sv
// ============================================================================
// tb_rtc_timer_sched : directed table plus hand sequences for rtc_timer_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rtc_timer_sched;

   localparam int          N    = 4;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        arm_i, cancel_i, ack_i, mti_i;
   logic [1:0]  slot_i;
   logic [63:0] deadline_i;
   logic        rtc_en_o;
   logic [7:0]  rtc_we_o;
   logic [3:0]  rtc_addr_o;
   logic [63:0] rtc_data_o;
   logic [N-1:0] expired_o;
   logic        irq_o, busy_o;
`ifdef RTC_SCHED_OVERRUN_EN
   logic [N-1:0] overrun_o;
`endif

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   logic [63:0] wr_data = '0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_we   = '0;

   always #5 clk = ~clk;

   rtc_timer_sched #(.NUM_SLOTS(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm_i      (arm_i),
      .cancel_i   (cancel_i),
      .slot_i     (slot_i),
      .deadline_i (deadline_i),
      .ack_i      (ack_i),
      .mti_i      (mti_i),
      .rtc_en_o   (rtc_en_o),
      .rtc_we_o   (rtc_we_o),
      .rtc_addr_o (rtc_addr_o),
      .rtc_data_o (rtc_data_o),
      .expired_o  (expired_o),
      .irq_o      (irq_o),
      .busy_o     (busy_o)
`ifdef RTC_SCHED_OVERRUN_EN
      ,
      .overrun_o  (overrun_o)
`endif
   );

   always @(negedge clk) begin
      if (rtc_en_o) begin
         wr_cnt  = wr_cnt + 1;
         wr_data = rtc_data_o;
         wr_addr = rtc_addr_o;
         wr_we   = rtc_we_o;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic a, input logic c, input logic k,
                     input logic [1:0] s, input logic [63:0] d);
      arm_i = a; cancel_i = c; ack_i = k; slot_i = s; deadline_i = d;
      tick();
      arm_i = 1'b0; cancel_i = 1'b0; ack_i = 1'b0;
   endtask

   task automatic mti_pulse();
      mti_i = 1'b1;
      tick();
      mti_i = 1'b0;
   endtask

   task automatic quiet(input string nm);
      int idle = 0;
      int n    = 0;
      while (idle < 3 && n < 200) begin
         tick();
         n++;
         idle = busy_o ? 0 : idle + 1;
      end
      chk({nm, "_settle"}, 64'(idle >= 3), 64'd1);
   endtask

   task automatic expect_write(input string nm, input int snap, input logic [63:0] d);
      chk({nm, "_wr_seen"}, 64'(wr_cnt > snap), 64'd1);
      chk({nm, "_wr_data"}, wr_data, d);
      chk({nm, "_wr_addr"}, 64'(wr_addr), 64'h8);
      chk({nm, "_wr_we"},   64'(wr_we), 64'hFF);
   endtask

   typedef struct {
      logic        arm;
      logic        cancel;
      logic [1:0]  slot;
      logic [63:0] dl;
      logic [63:0] exp_data;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int snap;
      int busy_cnt;
      int seen;

      tbl[0] = '{1'b1, 1'b0, 2'd2, 64'd100, 64'd100};
      tbl[1] = '{1'b1, 1'b0, 2'd0, 64'd50,  64'd50};
      tbl[2] = '{1'b1, 1'b0, 2'd3, 64'd50,  64'd50};
      tbl[3] = '{1'b0, 1'b1, 2'd0, 64'd0,   64'd50};
      tbl[4] = '{1'b0, 1'b1, 2'd3, 64'd0,   64'd100};
      tbl[5] = '{1'b1, 1'b0, 2'd1, 64'd300, 64'd100};
      tbl[6] = '{1'b0, 1'b1, 2'd2, 64'd0,   64'd300};
      tbl[7] = '{1'b1, 1'b1, 2'd2, 64'd70,  64'd70};
      tbl[8] = '{1'b0, 1'b1, 2'd1, 64'd0,   64'd70};

      reset_n = 1'b0; arm_i = 0; cancel_i = 0; ack_i = 0; mti_i = 0;
      slot_i = '0; deadline_i = '0;
      tick(); tick();
      chk("rst_busy",    64'(busy_o), 64'd0);
      chk("rst_en",      64'(rtc_en_o), 64'd0);
      chk("rst_data",    rtc_data_o, 64'd0);
      chk("rst_expired", 64'(expired_o), 64'd0);
      chk("rst_irq",     64'(irq_o), 64'd0);

      snap = wr_cnt;
      busy_cnt = 0;
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy_o) busy_cnt++;
      end
      chk("boot_busy_cycles", 64'(busy_cnt), 64'd7);
      chk("boot_wr_count",    64'(wr_cnt - snap), 64'd1);
      expect_write("boot", snap, ONES);

      // Table: each op lands in IDLE, last write must be the new minimum.
      for (int i = 0; i < 9; i++) begin
         snap = wr_cnt;
         op(tbl[i].arm, tbl[i].cancel, 1'b0, tbl[i].slot, tbl[i].dl);
         quiet($sformatf("tbl%0d", i));
         expect_write($sformatf("tbl%0d", i), snap, tbl[i].exp_data);
         chk($sformatf("tbl%0d_irq", i), 64'(irq_o), 64'd0);
      end
      snap = wr_cnt;
      op(1'b0, 1'b1, 1'b0, 2'd2, 64'd0);
      quiet("cancel_sole");
      expect_write("cancel_sole", snap, ONES);
      chk("cancel_sole_exp", 64'(expired_o), 64'd0);

      // Two arms back-to-back, then expire in deadline order.
      snap = wr_cnt;
      op(1'b1, 1'b0, 1'b0, 2'd2, 64'd100);
      op(1'b1, 1'b0, 1'b0, 2'd0, 64'd50);
      quiet("two_arm");
      expect_write("two_arm", snap, 64'd50);
      mti_pulse();
      chk("two_arm_exp0", 64'(expired_o), 64'b0001);
      chk("two_arm_irq",  64'(irq_o), 64'd1);
      snap = wr_cnt;
      quiet("two_arm_b");
      expect_write("two_arm_b", snap, 64'd100);
      op(1'b0, 1'b0, 1'b1, 2'd0, 64'd0);
      chk("two_arm_ack0", 64'(expired_o), 64'b0000);
      mti_pulse();
      chk("two_arm_exp2", 64'(expired_o), 64'b0100);
      quiet("two_arm_c");
      op(1'b0, 1'b0, 1'b1, 2'd2, 64'd0);
      chk("two_arm_irq_off", 64'(irq_o), 64'd0);

      // Equal deadlines expire one at a time, lowest index first.
      snap = wr_cnt;
      op(1'b1, 1'b0, 1'b0, 2'd1, 64'd200);
      op(1'b1, 1'b0, 1'b0, 2'd3, 64'd200);
      quiet("tie");
      expect_write("tie", snap, 64'd200);
      mti_pulse();
      chk("tie_exp1", 64'(expired_o), 64'b0010);
      snap = wr_cnt;
      quiet("tie_b");
      expect_write("tie_b", snap, 64'd200);
      mti_pulse();
      chk("tie_exp2", 64'(expired_o), 64'b1010);
      snap = wr_cnt;
      quiet("tie_c");
      expect_write("tie_c", snap, ONES);
      op(1'b0, 1'b0, 1'b1, 2'd1, 64'd0);
      chk("tie_irq_one_left", 64'(irq_o), 64'd1);
      op(1'b0, 1'b0, 1'b1, 2'd3, 64'd0);
      chk("tie_irq_clear", 64'(irq_o), 64'd0);

      // mti held through WAIT must not expire anything until IDLE.
      op(1'b1, 1'b0, 1'b0, 2'd0, 64'd500);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick();
         if (rtc_en_o) seen = 1;
      end
      chk("mask_prog_seen", 64'(seen), 64'd1);
      mti_i = 1'b1;
      tick(); chk("mask_wait1", 64'(expired_o), 64'd0);
      tick(); chk("mask_wait2", 64'(expired_o), 64'd0);
      tick(); chk("mask_idle",  64'(expired_o), 64'd0);
      chk("mask_idle_busy", 64'(busy_o), 64'd0);
      tick(); chk("mask_expire", 64'(expired_o), 64'b0001);
      mti_i = 1'b0;
      quiet("mask");
      op(1'b0, 1'b0, 1'b1, 2'd0, 64'd0);

      // Arm beats a same-cycle expiry of that slot; second expiry is an overrun.
      op(1'b1, 1'b0, 1'b0, 2'd1, 64'd10);
      quiet("race_a");
      snap = wr_cnt;
      mti_i = 1'b1;
      op(1'b1, 1'b0, 1'b0, 2'd1, 64'd20);
      mti_i = 1'b0;
      chk("race_exp", 64'(expired_o), 64'b0010);
      quiet("race_b");
      expect_write("race_rearm", snap, 64'd20);
      mti_pulse();
      chk("race_exp_again", 64'(expired_o), 64'b0010);
`ifdef RTC_SCHED_OVERRUN_EN
      chk("race_overrun", 64'(overrun_o), 64'b0010);
`endif
      snap = wr_cnt;
      quiet("race_c");
      expect_write("race_final", snap, ONES);
      op(1'b0, 1'b0, 1'b1, 2'd1, 64'd0);
      chk("race_ack", 64'(expired_o), 64'd0);
`ifdef RTC_SCHED_OVERRUN_EN
      chk("race_ack_ovr", 64'(overrun_o), 64'd0);
`endif

      // Set beats a same-cycle ack of the same bit.
      op(1'b1, 1'b0, 1'b0, 2'd0, 64'd5);
      quiet("ackset_a");
      mti_i = 1'b1;
      op(1'b0, 1'b0, 1'b1, 2'd0, 64'd0);
      mti_i = 1'b0;
      chk("ackset_exp", 64'(expired_o), 64'b0001);
      quiet("ackset_b");
      op(1'b0, 1'b0, 1'b1, 2'd0, 64'd0);
      chk("ackset_clear", 64'(expired_o), 64'd0);

      // Reset in the middle of SCAN: no write, state fully cleared.
      op(1'b1, 1'b0, 1'b0, 2'd0, 64'd9);
      tick(); tick();
      snap = wr_cnt;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_en",   64'(rtc_en_o), 64'd0);
      tick(); tick();
      chk("midrst_nowrite", 64'(wr_cnt - snap), 64'd0);
      reset_n = 1'b1;
      quiet("midrst");
      chk("midrst_one_write", 64'(wr_cnt - snap), 64'd1);
      expect_write("midrst", snap, ONES);
      chk("midrst_exp", 64'(expired_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
